spi_reg_cmd: RTL
================

SPI_REG_CMD -- requirements
Module: spi_reg_cmd

Interface
REQ-001 Parameter ADDR_W, default 4: register address width; 2**ADDR_W byte registers.
REQ-002 Parameter ID_VAL, default 8'hA5: read-only content of the top register (address 2**ADDR_W-1).
REQ-003 S_CLK  input  1  serial clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 i_SS  input  1  slave select, active low; high ends the frame.
REQ-006 i_RX_DV  input  1  one-S_CLK pulse; received byte valid.
REQ-007 i_RX_DATA  input  8  received MOSI byte.
REQ-008 i_TX_READY  input  1  slave serializer ready for the next byte.
REQ-009 o_TX_DATA  output  8  byte for the MISO serializer.
REQ-010 o_TX_DV  output  1  one-S_CLK pulse loading o_TX_DATA.
REQ-011 o_REG_BUS  output  8*2**ADDR_W  flattened register contents; register n at bits [8n+7:8n].
REQ-012 o_WR_STB  output  1  one-cycle pulse per committed register write.
REQ-013 o_ERR  output  1  sticky flag: command used an out-of-range address.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, READ and DISCARD.
REQ-015 In IDLE, an i_RX_DV byte is the command {rw, addr[6:0]}: rw=1 means read, rw=0 means write.
REQ-016 Address range: addr[6:ADDR_W] all zero means the address is valid; pointer <= addr[ADDR_W-1:0].
REQ-017 Valid write command: IDLE->WRITE; no register change on the command byte.
REQ-018 In WRITE, each i_RX_DV SHALL write i_RX_DATA to reg[pointer], pulse o_WR_STB on the next edge, and increment the pointer.
REQ-019 The pointer SHALL wrap from 2**ADDR_W-1 to 0.
REQ-020 Writes to the ID register SHALL be ignored: no o_WR_STB pulse, but the pointer still increments.
REQ-021 Valid read command: IDLE->READ; on the next edge o_TX_DATA <= reg[pointer] (ID_VAL for the top address), o_TX_DV pulses, and the pointer increments.
REQ-022 In READ, each i_RX_DV byte (a master dummy byte) SHALL be ignored.
REQ-023 In READ, each rising of i_TX_READY (0->1 across consecutive edges) SHALL load the next reg[pointer] with an o_TX_DV pulse, then increment the pointer.
REQ-024 Invalid address: IDLE->DISCARD and o_ERR <= 1; all further bytes are ignored until the frame ends.
REQ-025 i_SS high SHALL asynchronously force state IDLE, o_TX_DV=0 and o_WR_STB=0.
REQ-026 i_SS high SHALL preserve register contents, pointer, o_TX_DATA and o_ERR.
REQ-027 o_ERR SHALL clear only on reset or on a write of 8'h00 to register 0 with rw=0.
REQ-028 If i_RX_DV and a 0->1 transition of i_TX_READY coincide in READ, only the TX load SHALL occur.

Reset
REQ-029 reset low SHALL asynchronously set: state IDLE, pointer 0, all registers 8'h00, o_TX_DATA 8'h00, o_TX_DV 0, o_WR_STB 0, o_ERR 0.
REQ-030 A reset asserted mid-frame SHALL abort the frame; the first byte after release is treated as a command.

Structure
REQ-031 FSM state encodings, the command-bit positions (RW_BIT=7) and the default ID_VAL SHALL live in a shared package, spi_pkg.
REQ-032 The register file SHALL be one sub-module, spi_regfile: write port, combinational read port, flattened bus out.
REQ-033 The block has a single clock domain, S_CLK; no synchronizers inside.

Verification
REQ-034 Write burst: frame 8'h02, 8'h11, 8'h22 -> reg2=8'h11, reg3=8'h22, two o_WR_STB pulses, o_ERR=0.
REQ-035 Write wrap: frame 8'h0E, 8'hAA, 8'hBB, 8'hCC with ADDR_W=4 -> reg14=AA, reg15 (ID) unchanged, reg0=CC, two strobes.
REQ-036 Read burst: preload reg5=8'h5A, reg6=8'h6B; frame 8'h85, then two TX_READY rises -> o_TX_DATA sequence 5A, 6B, 8'h00 (reg7).
REQ-037 Range error: command 8'h40 followed by 8'hFF -> o_ERR=1, no strobe; then frame 8'h00, 8'h00 -> o_ERR=0.
REQ-038 Abort: i_SS high after write command 8'h03, before any data byte -> IDLE; next frame 8'h04, 8'h77 -> reg4=77, reg3 unchanged.
REQ-039 Reset mid-read: reset low during READ -> all outputs and registers at reset values immediately; the next byte is decoded as a command.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register command slave.
// Holds FSM encodings, command-byte layout and the default ID value.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    localparam int          RW_BIT     = 7;
    localparam logic [7:0]  ID_VAL_DEF = 8'hA5;

    // An address is in range when every bit above the register-address width is zero.
    function automatic logic addr_ok(input logic [6:0] addr, input int unsigned aw);
        return (addr >> aw) == 7'd0;
    endfunction

endpackage

// File: rtl/spi_reg_cmd_if.sv
// Byte-level handshake between the SPI serializer/deserializer and the register slave.
// The slave modport is the register block; the master modport is the SPI PHY side.
interface spi_reg_cmd_if #(
    parameter int ADDR_W = 4
);
    logic                          i_SS;
    logic                          i_RX_DV;
    logic [7:0]                    i_RX_DATA;
    logic                          i_TX_READY;
    logic [7:0]                    o_TX_DATA;
    logic                          o_TX_DV;
    logic [8*(2**ADDR_W)-1:0]      o_REG_BUS;
    logic                          o_WR_STB;
    logic                          o_ERR;

    modport slave (
        input  i_SS, i_RX_DV, i_RX_DATA, i_TX_READY,
        output o_TX_DATA, o_TX_DV, o_REG_BUS, o_WR_STB, o_ERR
    );

    modport master (
        output i_SS, i_RX_DV, i_RX_DATA, i_TX_READY,
        input  o_TX_DATA, o_TX_DV, o_REG_BUS, o_WR_STB, o_ERR
    );
endinterface

// File: rtl/spi_regfile.sv
// Byte register file: one write port, combinational read port, flattened bus out.
// The top address is the read-only ID register; it has no storage and reads as ID_VAL.
module spi_regfile #(
    parameter int         ADDR_W = 4,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic                     S_CLK,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [7:0]               wr_dat_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic [7:0]               rd_dat_o,
    output logic [8*(2**ADDR_W)-1:0] reg_bus_o
);
    localparam int                NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(NREG-1);

    logic [7:0] regs_q [NREG-1];

    always_ff @(posedge S_CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG-1; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en_i && (wr_addr_i != TOP)) begin
            regs_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = (rd_addr_i == TOP) ? ID_VAL : regs_q[rd_addr_i];

    // The ID slot on the bus reflects storage, which the ID register does not have.
    genvar n;
    generate
        for (n = 0; n < NREG-1; n++) begin : g_bus
            assign reg_bus_o[8*n +: 8] = regs_q[n];
        end
    endgenerate
    assign reg_bus_o[8*(NREG-1) +: 8] = 8'h00;

endmodule

// File: rtl/spi_reg_cmd.sv
// SPI register slave: first byte of a frame is {rw, addr}, then burst write or burst read.
// Reads present the first byte one edge after the command, further bytes on each TX_READY rise.
module spi_reg_cmd
    import spi_pkg::*;
#(
    parameter int         ADDR_W = 4,
    parameter logic [7:0] ID_VAL = ID_VAL_DEF
) (
    input  logic         S_CLK,
    input  logic         reset,
    spi_reg_cmd_if.slave bus
);
    localparam int                NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(NREG-1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_dv_q, tx_dv_d;
    logic                wr_stb_q, wr_stb_d;
    logic                err_q, err_d;
    logic                load_pend_q, load_pend_d;
    logic                tx_ready_q;

    logic                rx_dv;
    logic                tx_rise;
    logic                wr_en;
    logic [7:0]          rd_dat;

    // A byte strobed while deselected must not be decoded as a command.
    assign rx_dv   = bus.i_RX_DV & ~bus.i_SS;
    assign tx_rise = bus.i_TX_READY & ~tx_ready_q;

    spi_regfile #(
        .ADDR_W (ADDR_W),
        .ID_VAL (ID_VAL)
    ) u_regfile (
        .S_CLK     (S_CLK),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (ptr_q),
        .wr_dat_i  (bus.i_RX_DATA),
        .rd_addr_i (ptr_q),
        .rd_dat_o  (rd_dat),
        .reg_bus_o (bus.o_REG_BUS)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        tx_dv_d     = 1'b0;
        wr_stb_d    = 1'b0;
        err_d       = err_q;
        load_pend_d = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (addr_ok(bus.i_RX_DATA[RW_BIT-1:0], ADDR_W)) begin
                        ptr_d       = bus.i_RX_DATA[ADDR_W-1:0];
                        state_d     = bus.i_RX_DATA[RW_BIT] ? ST_READ : ST_WRITE;
                        load_pend_d = bus.i_RX_DATA[RW_BIT];
                    end else begin
                        state_d = ST_DISCARD;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (rx_dv) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q != TOP) begin
                        wr_en    = 1'b1;
                        wr_stb_d = 1'b1;
                    end
                    if ((ptr_q == '0) && (bus.i_RX_DATA == 8'h00)) begin
                        err_d = 1'b0;
                    end
                end
            end
            ST_READ: begin
                // Dummy MOSI bytes are ignored; only the pending first load or a READY rise loads.
                if (load_pend_q || tx_rise) begin
                    tx_data_d = rd_dat;
                    tx_dv_d   = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                end
            end
            ST_DISCARD: begin
                state_d = ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame-scoped state: deselect forces it idle without waiting for a clock.
    always_ff @(posedge S_CLK or negedge reset or posedge bus.i_SS) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tx_dv_q     <= 1'b0;
            wr_stb_q    <= 1'b0;
            load_pend_q <= 1'b0;
        end else if (bus.i_SS) begin
            state_q     <= ST_IDLE;
            tx_dv_q     <= 1'b0;
            wr_stb_q    <= 1'b0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_dv_q     <= tx_dv_d;
            wr_stb_q    <= wr_stb_d;
            load_pend_q <= load_pend_d;
        end
    end

    // State that survives deselect.
    always_ff @(posedge S_CLK or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            err_q      <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            tx_ready_q <= bus.i_TX_READY;
        end
    end

    assign bus.o_TX_DATA = tx_data_q;
    assign bus.o_TX_DV   = tx_dv_q;
    assign bus.o_WR_STB  = wr_stb_q;
    assign bus.o_ERR     = err_q;

endmodule
